// File: rtl/cpu_soc_pkg.sv
// Shared definitions for the CPU/monitor memory sequencer.
// State encoding, default address width and a parameter clamp helper.
package cpu_soc_pkg;

    localparam int ADDR_WIDTH = 9;

    typedef enum logic [2:0] {
        MON     = 3'd0,
        BOOT    = 3'd1,
        RUN     = 3'd2,
        HALTREQ = 3'd3,
        DRAIN   = 3'd4
    } state_t;

    // A zero cycle count behaves as a single cycle.
    function automatic int clamp1(input int v);
        return (v < 1) ? 1 : v;
    endfunction

endpackage

// File: rtl/mem_owner_mux.sv
// RAM port mux between monitor and CPU.
// The non-owner's write strobe never reaches the RAM.
import cpu_soc_pkg::*;

module mem_owner_mux #(
    parameter int addr_width = ADDR_WIDTH
) (
    input  logic                  i_owner_mon,
    input  logic [addr_width-1:0] i_mon_raddr,
    input  logic [addr_width-1:0] i_mon_waddr,
    input  logic [7:0]            i_mon_wdata,
    input  logic                  i_mon_write,
    input  logic [addr_width-1:0] i_cpu_raddr,
    input  logic [addr_width-1:0] i_cpu_waddr,
    input  logic [7:0]            i_cpu_wdata,
    input  logic                  i_cpu_write,
    input  logic [7:0]            i_mem_rdata,
    output logic [addr_width-1:0] o_mem_raddr,
    output logic [addr_width-1:0] o_mem_waddr,
    output logic [7:0]            o_mem_wdata,
    output logic                  o_mem_write,
    output logic [7:0]            o_mon_rdata,
    output logic [7:0]            o_cpu_rdata
);

    // Select the owner's address/data; read data goes to both sides.
    always_comb begin
        o_mem_raddr = i_cpu_raddr;
        o_mem_waddr = i_cpu_waddr;
        o_mem_wdata = i_cpu_wdata;
        o_mem_write = i_cpu_write;
        if (i_owner_mon) begin
            o_mem_raddr = i_mon_raddr;
            o_mem_waddr = i_mon_waddr;
            o_mem_wdata = i_mon_wdata;
            o_mem_write = i_mon_write;
        end
        o_mon_rdata = i_mem_rdata;
        o_cpu_rdata = i_mem_rdata;
    end

endmodule

// File: rtl/cpu_mem_sequencer.sv
// Hands the program RAM between monitor and CPU, and drives the CPU's
// reset/halt/start-address pins through boot, run and halt sequences.
import cpu_soc_pkg::*;

module cpu_mem_sequencer #(
    parameter int addr_width   = ADDR_WIDTH,
    parameter int boot_cycles  = 2,
    parameter int halt_timeout = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  mon_req,
    input  logic                  mon_run,
    input  logic [addr_width-1:0] mon_start_addr,
    input  logic [addr_width-1:0] mon_raddr,
    input  logic [addr_width-1:0] mon_waddr,
    input  logic [7:0]            mon_wdata,
    input  logic                  mon_write,
    output logic                  mon_gnt,
    output logic [7:0]            mon_rdata,
    input  logic [addr_width-1:0] cpu_raddr,
    input  logic [addr_width-1:0] cpu_waddr,
    input  logic [7:0]            cpu_wdata,
    input  logic                  cpu_write,
    input  logic                  cpu_halted,
    output logic [7:0]            cpu_rdata,
    output logic                  cpu_reset,
    output logic                  cpu_halt,
    output logic [addr_width-1:0] cpu_start_address,
    output logic [addr_width-1:0] mem_raddr,
    output logic [addr_width-1:0] mem_waddr,
    output logic [7:0]            mem_wdata,
    output logic                  mem_write,
    input  logic [7:0]            mem_rdata,
    output logic                  cpu_done,
    output logic                  timeout_err
);

    localparam logic [7:0] BOOT_LD = 8'(clamp1(boot_cycles) - 1);
    localparam logic [7:0] HALT_LD = 8'(clamp1(halt_timeout) - 1);

    state_t                r_state;
    logic [7:0]            r_cnt;
    logic                  r_mon_gnt;
    logic                  r_cpu_reset;
    logic                  r_cpu_halt;
    logic                  r_cpu_done;
    logic                  r_timeout_err;
    logic [addr_width-1:0] r_start_addr;

    // Control FSM: ownership, CPU pins and the shared boot/halt counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= MON;
            r_cnt         <= '0;
            r_mon_gnt     <= 1'b1;
            r_cpu_reset   <= 1'b1;
            r_cpu_halt    <= 1'b1;
            r_cpu_done    <= 1'b0;
            r_timeout_err <= 1'b0;
            r_start_addr  <= '0;
        end else begin
            r_cpu_done <= 1'b0;
            unique case (r_state)
                MON: begin
                    if (mon_run) begin
                        r_start_addr  <= mon_start_addr;
                        r_timeout_err <= 1'b0;
                        r_cnt         <= BOOT_LD;
                        r_mon_gnt     <= 1'b0;
                        r_cpu_halt    <= 1'b0;
                        r_state       <= BOOT;
                    end
                end
                BOOT: begin
                    if (r_cnt == 8'd0) begin
                        r_cpu_reset <= 1'b0;
                        r_state     <= RUN;
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                RUN: begin
                    r_cpu_done <= cpu_halted;
                    if (mon_req) begin
                        r_cpu_halt <= 1'b1;
                        if (cpu_halted) begin
                            r_state <= DRAIN;
                        end else begin
                            r_cnt   <= HALT_LD;
                            r_state <= HALTREQ;
                        end
                    end
                end
                HALTREQ: begin
                    if (cpu_halted) begin
                        r_state <= DRAIN;
                    end else if (r_cnt == 8'd0) begin
                        r_timeout_err <= 1'b1;
                        r_cpu_reset   <= 1'b1;
                        r_state       <= DRAIN;
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                DRAIN: begin
                    r_mon_gnt   <= 1'b1;
                    r_cpu_reset <= 1'b1;
                    r_cpu_halt  <= 1'b1;
                    r_state     <= MON;
                end
                default: begin
                    r_mon_gnt   <= 1'b1;
                    r_cpu_reset <= 1'b1;
                    r_cpu_halt  <= 1'b1;
                    r_state     <= MON;
                end
            endcase
        end
    end

    assign mon_gnt           = r_mon_gnt;
    assign cpu_reset         = r_cpu_reset;
    assign cpu_halt          = r_cpu_halt;
    assign cpu_start_address = r_start_addr;
    assign cpu_done          = r_cpu_done;
    assign timeout_err       = r_timeout_err;

    mem_owner_mux #(
        .addr_width (addr_width)
    ) u_mux (
        .i_owner_mon (r_mon_gnt),
        .i_mon_raddr (mon_raddr),
        .i_mon_waddr (mon_waddr),
        .i_mon_wdata (mon_wdata),
        .i_mon_write (mon_write),
        .i_cpu_raddr (cpu_raddr),
        .i_cpu_waddr (cpu_waddr),
        .i_cpu_wdata (cpu_wdata),
        .i_cpu_write (cpu_write),
        .i_mem_rdata (mem_rdata),
        .o_mem_raddr (mem_raddr),
        .o_mem_waddr (mem_waddr),
        .o_mem_wdata (mem_wdata),
        .o_mem_write (mem_write),
        .o_mon_rdata (mon_rdata),
        .o_cpu_rdata (cpu_rdata)
    );

endmodule
